// File: rtl/dsp_mem_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// dsp_mem_sequencer_pkg
// Shared definitions for the DSP data-memory sequencer: memory-stage op
// encodings, default widths, FSM state codes and arbiter grant codes.
// Optional feature macro used by the sequencer: DSP_MEM_STACK_CHECK_EN.
// ---------------------------------------------------------------------------
package dsp_mem_sequencer_pkg;

  localparam int MEM_ADDR_LEN = 16;
  localparam int REG_WORD_LEN = 16;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Memory-stage op encodings driven by the core decode
  localparam logic [2:0] MEM_NONE   = 3'd0;
  localparam logic [2:0] MEM_LD_IMM = 3'd1;
  localparam logic [2:0] MEM_LD     = 3'd2;
  localparam logic [2:0] MEM_ST     = 3'd3;
  localparam logic [2:0] MEM_PUSH   = 3'd4;
  localparam logic [2:0] MEM_POP    = 3'd5;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } state_e;

  // Encoding of the round-robin last_grant bit
  localparam logic GRANT_CORE = 1'b0;
  localparam logic GRANT_DMA  = 1'b1;

  // True for ops that need the SRAM port
  function automatic logic mem_is_access(input logic [2:0] mode);
    return (mode == MEM_LD) || (mode == MEM_ST) ||
           (mode == MEM_PUSH) || (mode == MEM_POP);
  endfunction

  // True for ops that return data one cycle after issue
  function automatic logic mem_is_read(input logic [2:0] mode);
    return (mode == MEM_LD) || (mode == MEM_POP);
  endfunction

endpackage

// File: rtl/dsp_mem_sequencer_rr_arb.sv
// ---------------------------------------------------------------------------
// dsp_mem_rr_arb
// Two-requester round-robin arbiter. On a tie the requester that did not win
// last time is granted. last_grant resets to DMA so the core wins the first
// tie.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   req_core_i, req_dma_i requests
//   grant_core_o          core granted this cycle (combinational)
//   grant_dma_o           DMA granted this cycle (combinational)
// ---------------------------------------------------------------------------
module dsp_mem_rr_arb
  import dsp_mem_sequencer_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_core_i,
  input  logic req_dma_i,
  output logic grant_core_o,
  output logic grant_dma_o
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    grant_core_o = req_core_i && (!req_dma_i || (last_grant_q == GRANT_DMA));
    grant_dma_o  = req_dma_i && (!req_core_i || (last_grant_q == GRANT_CORE));
    last_grant_d = last_grant_q;
    if (grant_core_o) begin
      last_grant_d = GRANT_CORE;
    end else if (grant_dma_o) begin
      last_grant_d = GRANT_DMA;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= GRANT_DMA;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/dsp_mem_sequencer.sv
// ---------------------------------------------------------------------------
// dsp_mem_sequencer
// Serialises core memory-stage ops (LD/ST/PUSH/POP) and the sample-DMA write
// stream onto one single-port synchronous SRAM. Owns the hardware stack
// pointer (descending, pre-decrement PUSH) and the circular ring write index.
// Optional feature: define DSP_MEM_STACK_CHECK_EN to add stack bound checks
// and the sticky stack_err output.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   core_req/mode/addr/wdata         memory-stage op from the core
//   core_stall/rvalid/rdata          handshake and read return to the core
//   dma_valid/data, dma_ready        sample write stream
//   mem_en/we/addr/wdata, mem_rdata  SRAM port (read data one cycle later)
//   sp, ring_wr_idx, ring_wrap       stack pointer, ring index, wrap pulse
//   stack_err                        sticky stack fault (macro builds only)
// ---------------------------------------------------------------------------
module dsp_mem_sequencer
  import dsp_mem_sequencer_pkg::*;
#(
  parameter int                ADDR_W     = MEM_ADDR_LEN,
  parameter int                DATA_W     = REG_WORD_LEN,
  parameter logic [ADDR_W-1:0] STACK_BASE = 16'h0F00,
  parameter logic [ADDR_W-1:0] STACK_SIZE = 16'h0100,
  parameter logic [ADDR_W-1:0] RING_BASE  = 16'h0800,
  parameter int                RING_SIZE  = 64,
  localparam int               RING_IDX_W = $clog2(RING_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  core_req,
  input  logic [2:0]            core_mode,
  input  logic [ADDR_W-1:0]     core_addr,
  input  logic [DATA_W-1:0]     core_wdata,
  output logic                  core_stall,
  output logic                  core_rvalid,
  output logic [DATA_W-1:0]     core_rdata,
  input  logic                  dma_valid,
  input  logic [DATA_W-1:0]     dma_data,
  output logic                  dma_ready,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [ADDR_W-1:0]     sp,
  output logic [RING_IDX_W-1:0] ring_wr_idx,
`ifdef DSP_MEM_STACK_CHECK_EN
  output logic                  stack_err,
`endif
  output logic                  ring_wrap
);

  localparam logic [ADDR_W-1:0] STACK_TOP = STACK_BASE + STACK_SIZE;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     sp_q, sp_d;
  logic [RING_IDX_W-1:0] idx_q, idx_d;
  logic                  wrap_q, wrap_d;
  logic                  rd_fault_q, rd_fault_d;
`ifdef DSP_MEM_STACK_CHECK_EN
  logic                  err_q, err_d;
`endif

  logic                  core_mem_op;
  logic                  core_is_read;
  logic                  grant_core, grant_dma;
  logic                  stack_fault;
  logic                  en_c, we_c;
  logic [ADDR_W-1:0]     addr_c;
  logic [DATA_W-1:0]     wdata_c;

  assign core_mem_op  = core_req && mem_is_access(core_mode);
  assign core_is_read = mem_is_read(core_mode);

  // The core only competes in IDLE; in RD_WAIT its op is being completed,
  // so the free port goes to the DMA if it asks.
  dsp_mem_rr_arb u_arb (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_core_i   (core_mem_op && (state_q == ST_IDLE)),
    .req_dma_i    (dma_valid),
    .grant_core_o (grant_core),
    .grant_dma_o  (grant_dma)
  );

`ifdef DSP_MEM_STACK_CHECK_EN
  assign stack_fault = ((core_mode == MEM_PUSH) && (sp_q == STACK_BASE)) ||
                       ((core_mode == MEM_POP)  && (sp_q == STACK_TOP));
`else
  assign stack_fault = FALSE;
`endif

  always_comb begin
    state_d    = ST_IDLE;
    sp_d       = sp_q;
    idx_d      = idx_q;
    wrap_d     = FALSE;
    rd_fault_d = FALSE;
`ifdef DSP_MEM_STACK_CHECK_EN
    err_d      = err_q;
`endif
    en_c       = FALSE;
    we_c       = FALSE;
    addr_c     = '0;
    wdata_c    = '0;
    if (grant_core) begin
      state_d = core_is_read ? ST_RD_WAIT : ST_IDLE;
      if (stack_fault) begin
        // Faulting op is consumed without touching the SRAM; a faulting POP
        // still takes the read path and returns zero.
        rd_fault_d = core_is_read;
`ifdef DSP_MEM_STACK_CHECK_EN
        err_d      = TRUE;
`endif
      end else begin
        case (core_mode)
          MEM_ST: begin
            en_c = TRUE; we_c = TRUE; addr_c = core_addr; wdata_c = core_wdata;
          end
          MEM_LD: begin
            en_c = TRUE; addr_c = core_addr;
          end
          MEM_PUSH: begin
            en_c = TRUE; we_c = TRUE; wdata_c = core_wdata;
            addr_c = sp_q - ADDR_W'(1);
            sp_d   = sp_q - ADDR_W'(1);
          end
          MEM_POP: begin
            en_c = TRUE; addr_c = sp_q;
            sp_d = sp_q + ADDR_W'(1);
          end
          default: ;
        endcase
      end
    end else if (grant_dma) begin
      en_c    = TRUE;
      we_c    = TRUE;
      addr_c  = RING_BASE + ADDR_W'(idx_q);
      wdata_c = dma_data;
      idx_d   = idx_q + 1'b1;  // power-of-two depth: wraps naturally
      wrap_d  = (idx_q == {RING_IDX_W{1'b1}});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sp_q       <= STACK_TOP;
      idx_q      <= '0;
      wrap_q     <= FALSE;
      rd_fault_q <= FALSE;
`ifdef DSP_MEM_STACK_CHECK_EN
      err_q      <= FALSE;
`endif
    end else begin
      state_q    <= state_d;
      sp_q       <= sp_d;
      idx_q      <= idx_d;
      wrap_q     <= wrap_d;
      rd_fault_q <= rd_fault_d;
`ifdef DSP_MEM_STACK_CHECK_EN
      err_q      <= err_d;
`endif
    end
  end

  // Combinational outputs are forced low during reset because the grant
  // itself depends on live request inputs.
  assign mem_en      = rst_n && en_c;
  assign mem_we      = rst_n && we_c;
  assign mem_addr    = rst_n ? addr_c  : '0;
  assign mem_wdata   = rst_n ? wdata_c : '0;
  assign dma_ready   = rst_n && grant_dma;
  assign core_stall  = rst_n && ((core_mem_op && (state_q == ST_IDLE) && !grant_core) ||
                                 (grant_core && core_is_read));
  assign core_rvalid = rst_n && (state_q == ST_RD_WAIT);
  assign core_rdata  = (core_rvalid && !rd_fault_q) ? mem_rdata : '0;
  assign sp          = sp_q;
  assign ring_wr_idx = idx_q;
  assign ring_wrap   = wrap_q;
`ifdef DSP_MEM_STACK_CHECK_EN
  assign stack_err   = err_q;
`endif

endmodule

// File: doc/dsp_mem_sequencer.md
# dsp_mem_sequencer

Sequences the DSP data memory, a single-port synchronous SRAM, between the core's memory stage and the receiver's sample-DMA write stream. It sits between the memory-stage decode (`mem_mode`, address, store data) and the SRAM macro. It owns three things: the hardware stack pointer for PUSH/POP, the circular sample-ring write index, and the arbitration plus stall handshake that serialise core and DMA accesses onto the one port.

## Interface
- `ADDR_W`, default `MEM_ADDR_LEN` (16): memory address width.
- `DATA_W`, default `REG_WORD_LEN` (16): data word width.
- `STACK_BASE`, default 16'h0F00: lowest stack address, the full limit.
- `STACK_SIZE`, default 16'h0100: stack depth in words; `STACK_TOP = STACK_BASE + STACK_SIZE` is the empty value.
- `RING_BASE`, default 16'h0800: sample ring base address.
- `RING_SIZE`, default 64: ring depth, a power of two.

Ports:
- `clk`, in, 1: the single clock; all state changes on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `core_req`, in, 1: the core has a memory-stage op this cycle.
- `core_mode`, in, 3: `MEM_*` encoding from the shared definitions.
- `core_addr`, in, `ADDR_W`: LD/ST address.
- `core_wdata`, in, `DATA_W`: ST/PUSH data.
- `core_stall`, out, 1: the core holds all `core_*` inputs stable while this is high.
- `core_rvalid`, out, 1: LD/POP data valid this cycle.
- `core_rdata`, out, `DATA_W`: read data; 0 when `core_rvalid` is low.
- `dma_valid`, in, 1: a sample word is offered.
- `dma_data`, in, `DATA_W`: the sample word.
- `dma_ready`, out, 1: the sample is accepted this cycle.
- `mem_en`, out, 1: SRAM access enable.
- `mem_we`, out, 1: SRAM write enable.
- `mem_addr`, out, `ADDR_W`: SRAM address.
- `mem_wdata`, out, `DATA_W`: SRAM write data.
- `mem_rdata`, in, `DATA_W`: SRAM read data, valid the cycle after a read issue.
- `sp`, out, `ADDR_W`: current stack pointer.
- `ring_wr_idx`, out, log2(`RING_SIZE`): next ring slot.
- `ring_wrap`, out, 1: one-cycle pulse when the index wraps to 0.
- `stack_err`, out, 1: sticky stack fault; present only with the config macro.

## Operation
- Op classes:
  - `MEM_NONE` and `MEM_LD_IMM` make no access, never stall and complete at once.
  - `MEM_ST` and `MEM_PUSH` are writes.
  - `MEM_LD` and `MEM_POP` are reads.
- Address and pointer rules:
  - ST writes `core_wdata` to `core_addr`; LD reads `core_addr`.
  - PUSH writes to `sp-1` and `sp` is updated to `sp-1` at the grant edge (pre-decrement, descending stack).
  - POP reads `sp` and `sp` is updated to `sp+1` at the grant edge.
  - All pointer arithmetic is modulo 2^`ADDR_W`.
- State machine:
  - IDLE:
    - Arbitrates between the core (`core_req` with a memory op) and the DMA (`dma_valid`).
    - If only one requests, that one is granted.
    - If both request, grant goes round-robin on the `last_grant` bit.
    - A granted read moves to RD_WAIT. Writes stay in IDLE.
  - RD_WAIT:
    - `core_rvalid` = 1, `core_rdata` = `mem_rdata`, `core_stall` = 0, and the state returns to IDLE next cycle.
    - The port is free in this cycle, so a pending DMA write is granted here.
- Stall rule: `core_stall` = 1 when the core has a memory op and is not granted, and in the grant cycle of a read.
- A write completes in its grant cycle with `core_stall` = 0.
- DMA:
  - Writes `dma_data` to `RING_BASE + ring_wr_idx`, then `ring_wr_idx` is incremented.
  - `dma_ready` equals the DMA grant and is a combinational function of the current state and requests.
  - At `RING_SIZE-1` the index wraps to 0 and `ring_wrap` pulses for one cycle.
  - The ring overwrites without back-pressure; overrun is software's concern.
- `mem_*` outputs are combinational from the grant. With no grant they are all 0.

## Timing
- Reset: async assert forces state to IDLE, `sp` = `STACK_TOP`, `ring_wr_idx` = 0, `last_grant` = DMA (so the core wins the first tie), and `stack_err` = 0.
- While `rst_n` is low all outputs are 0 except `sp`, which is `STACK_TOP`.
- A read in flight when reset asserts is dropped, with no `core_rvalid`.
- Write latency is 0 extra cycles. Read latency is 1: issue at edge N, data at edge N+1.
- A core op stalled by the DMA waits at most one cycle, because round-robin grants the core next.
- Simultaneous PUSH grant and DMA request: the DMA waits. `sp` and `ring_wr_idx` never change in the same cycle from the same requester.

## Configuration
- `DSP_MEM_STACK_CHECK_EN` defined:
  - A PUSH with `sp == STACK_BASE`, or a POP with `sp == STACK_TOP`, makes no SRAM access and leaves `sp` unchanged.
  - It sets `stack_err`, which stays set until reset.
  - The faulting POP keeps normal read timing: it still passes through RD_WAIT, with `core_rdata` = 0.
- Undefined: no `stack_err` port, no checks, and `sp` wraps modulo 2^`ADDR_W`.

## Structure
- The `MEM_*` encodings, `MEM_ADDR_LEN`, `REG_WORD_LEN`, `TRUE`/`FALSE` and the FSM state codes belong in the shared `definitions.v`.
- Sub-module `dsp_mem_rr_arb`: a two-requester round-robin arbiter holding `last_grant`, with outputs `grant_core` and `grant_dma`.
- The FSM, stack pointer, ring index and memory muxing live in the top module.

## Test plan
- Reset, then PUSH 0xBEEF → `mem_addr` = 0x0FFF, `mem_we` = 1, `sp` = 0x0FFF; POP → `mem_addr` = 0x0FFF, next cycle `core_rvalid` = 1, `core_rdata` = 0xBEEF, `sp` = 0x1000.
- Core LD 0x0123 and `dma_valid` in the same cycle after reset → core granted first; in RD_WAIT the DMA write goes to 0x0800; `core_stall` = 1 for exactly 1 cycle.
- 64 DMA words back-to-back with no core traffic → addresses 0x0800–0x083F; `ring_wrap` pulses on word 64; `ring_wr_idx` = 0.
- Alternating ST and DMA requests held every cycle → grants strictly alternate; each ST is stalled at most 1 cycle.
- With `DSP_MEM_STACK_CHECK_EN`, POP right after reset → no `mem_en`; `core_rdata` = 0 one cycle later; `stack_err` = 1; `sp` = 0x1000.
- `rst_n` pulled low in the LD grant cycle → no `core_rvalid` and state IDLE after release.
